// File: rtl/cp0_redirect_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions, exception codes and
// default handler/PRId values.
package cp0_redirect_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int unsigned SR_IE        = 0;
    localparam int unsigned SR_EXL       = 1;
    localparam int unsigned SR_IM_LO     = 10;
    localparam int unsigned SR_IM_HI     = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_VAL_DEF   = 32'h2019_0007;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_redirect.sv
// M-stage CP0: interrupt/exception/eret decision, SR/Cause/EPC state and the
// combinational flush + redirect PC sent back toward fetch.
module cp0_redirect
    import cp0_redirect_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] PRID_VAL   = PRID_VAL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_M,
    input  logic        valid_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic        eret_M,
    input  logic [5:0]  HWInt,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [31:0] EPC_out,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q;
    logic [31:0] epc_q;

    logic        req_en;
    logic        int_req;
    logic        exc_req;
    logic        take;
    logic        eret_go;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Gating with reset keeps redirect low while reset is held, even for exceptions.
    assign req_en  = valid_M & reset;
    assign int_req = req_en & ie_q & ~exl_q & (|(HWInt & im_q));
    assign exc_req = req_en & ~exl_q & (ExcCode_M != 5'd0);
    assign take    = int_req | exc_req;
    assign eret_go = req_en & eret_M & ~take;

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if (take) begin
            redirect    = 1'b1;
            redirect_pc = HANDLER_PC;
        end else if (eret_go) begin
            redirect    = 1'b1;
            redirect_pc = epc_q;
        end
    end

    always_comb begin
        sr_word                              = 32'h0;
        sr_word[SR_IM_HI:SR_IM_LO]           = im_q;
        sr_word[SR_EXL]                      = exl_q;
        sr_word[SR_IE]                       = ie_q;
        cause_word                           = 32'h0;
        cause_word[CAUSE_BD]                 = bd_q;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]  = ip_q;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
    end

    always_comb begin
        dout = 32'h0;
        case (addr)
            CP0_SR:    dout = sr_word;
            CP0_CAUSE: dout = cause_word;
            CP0_EPC:   dout = epc_q;
            CP0_PRID:  dout = PRID_VAL;
            default:   dout = 32'h0;
        endcase
    end

    assign EPC_out = epc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= 6'h0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= 6'h0;
            exc_q <= 5'h0;
            epc_q <= 32'h0;
        end else begin
            ip_q <= HWInt;
            if (take) begin
                exl_q <= 1'b1;
                exc_q <= int_req ? EXC_INT : ExcCode_M;
                bd_q  <= BD_M;
                epc_q <= word_align(BD_M ? (PC_M - 32'd4) : PC_M);
            end else if (eret_go) begin
                exl_q <= 1'b0;
            end
            // A faulting or interrupted mtc0 must not commit.
            if (we && !take) begin
                case (addr)
                    CP0_SR: begin
                        im_q  <= din[SR_IM_HI:SR_IM_LO];
                        exl_q <= din[SR_EXL];
                        ie_q  <= din[SR_IE];
                    end
                    CP0_EPC: epc_q <= word_align(din);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_redirect.sv
// Randomised + directed bench for cp0_redirect; a behavioural model predicts each cycle's
// outputs into a queue that a separate monitor drains and compares.
module tb_cp0_redirect;
    import cp0_redirect_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC_M = '0;
    logic        valid_M = 1'b0;
    logic        BD_M = 1'b0;
    logic [4:0]  ExcCode_M = '0;
    logic        eret_M = 1'b0;
    logic [5:0]  HWInt = '0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [31:0] EPC_out;
    logic        redirect;
    logic [31:0] redirect_pc;

    cp0_redirect dut (
        .clk(clk), .reset(reset), .PC_M(PC_M), .valid_M(valid_M), .BD_M(BD_M),
        .ExcCode_M(ExcCode_M), .eret_M(eret_M), .HWInt(HWInt), .we(we), .addr(addr),
        .din(din), .dout(dout), .EPC_out(EPC_out), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Architectural model state.
    int unsigned m_im, m_exl, m_ie, m_bd, m_ip, m_code;
    logic [31:0] m_epc;

    task automatic model_clear();
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip = 0; m_code = 0; m_epc = 0;
    endtask

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pin("redirect", {31'b0, redirect}, {31'b0, e.redir});
                pin("redirect_pc", redirect_pc, e.rpc);
                pin("dout", dout, e.rd);
                pin("epc_out", EPC_out, e.epc);
            end
        end
    end

    task automatic step(input logic rstv, input logic vm, input logic bd, input logic [4:0] code,
                        input logic er, input logic [5:0] hw, input logic w,
                        input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        exp_t e;
        bit   irq, exc, tk, ert;
        @(posedge clk);
        #1;
        reset = rstv; valid_M = vm; BD_M = bd; ExcCode_M = code; eret_M = er;
        HWInt = hw; we = w; addr = a; din = d; PC_M = pc;
        if (!rstv) model_clear();
        irq = rstv && vm && m_ie == 1 && m_exl == 0 && ((hw & m_im[5:0]) != 0);
        exc = rstv && vm && m_exl == 0 && code != 0;
        tk  = irq || exc;
        ert = rstv && vm && er && !tk;
        e.redir = tk || ert;
        e.rpc   = tk ? 32'h0000_4180 : (ert ? m_epc : 32'h0);
        e.epc   = m_epc;
        case (a)
            5'd12:   e.rd = m_im * 1024 + m_exl * 2 + m_ie;
            5'd13:   e.rd = m_bd * 32'h8000_0000 + m_ip * 1024 + m_code * 4;
            5'd14:   e.rd = m_epc;
            5'd15:   e.rd = 32'h2019_0007;
            default: e.rd = 32'h0;
        endcase
        exp_q.push_back(e);
        if (rstv) begin
            m_ip = hw;
            if (tk) begin
                m_exl  = 1;
                m_code = irq ? 0 : code;
                m_bd   = bd;
                m_epc  = (bd ? pc - 4 : pc) & 32'hFFFF_FFFC;
            end else if (ert) begin
                m_exl = 0;
            end
            if (w && !tk) begin
                if (a == 5'd12) begin
                    m_im = d[15:10]; m_exl = d[1]; m_ie = d[0];
                end else if (a == 5'd14) begin
                    m_epc = d & 32'hFFFF_FFFC;
                end
            end
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [5:0] hw);
        step(1, 0, 0, 0, 0, hw, 0, a, 0, 0);
    endtask

    initial begin : driver
        logic [4:0]  codes [5];
        logic [4:0]  addrs [6];
        logic [4:0]  c, a;
        model_clear();
        codes[0] = 0; codes[1] = EXC_ADEL; codes[2] = EXC_ADES; codes[3] = EXC_RI;
        codes[4] = EXC_OV;
        addrs[0] = 12; addrs[1] = 13; addrs[2] = 14; addrs[3] = 15; addrs[4] = 0; addrs[5] = 7;

        step(0, 0, 0, 0, 0, 0, 0, 15, 0, 0);
        rd(15, 0);
        @(negedge clk); pin("prid", dout, 32'h2019_0007);
        rd(12, 0);
        @(negedge clk); pin("sr_reset", dout, 32'h0);

        // Interrupt on IM[10]
        step(1, 0, 0, 0, 0, 0, 1, 12, 32'h0000_0401, 0);
        step(1, 1, 0, 0, 0, 6'b000001, 0, 13, 0, 32'h0000_3010);
        @(negedge clk); pin("int_rpc", redirect_pc, 32'h0000_4180);
        rd(14, 6'b000001);
        @(negedge clk); pin("int_epc", dout, 32'h0000_3010);
        rd(13, 6'b000001);
        @(negedge clk); pin("int_cause", dout, 32'h0000_0400);
        step(1, 1, 0, 0, 1, 0, 0, 12, 0, 32'h0000_3014);

        // Overflow in a delay slot
        step(1, 1, 1, EXC_OV, 0, 0, 0, 12, 0, 32'h0000_3024);
        rd(13, 0);
        @(negedge clk); pin("ov_cause", dout, 32'h8000_0030);
        rd(14, 0);
        @(negedge clk); pin("ov_epc", dout, 32'h0000_3020);

        // eret returns to EPC
        step(1, 1, 0, 0, 1, 0, 0, 12, 0, 32'h0000_4200);
        @(negedge clk); pin("eret_rpc", redirect_pc, 32'h0000_3020);
        rd(12, 0);
        @(negedge clk); pin("eret_sr", dout, 32'h0000_0401);

        // Interrupt deferred across bubbles
        repeat (3) begin
            rd(12, 6'b000001);
            @(negedge clk); pin("bubble_noredir", {31'b0, redirect}, 32'h0);
        end
        step(1, 1, 0, 0, 0, 6'b000001, 0, 12, 0, 32'h0000_3040);
        @(negedge clk); pin("deferred_take", {31'b0, redirect}, 32'h1);
        step(1, 1, 0, 0, 1, 0, 0, 12, 0, 32'h0000_4188);

        // mtc0 EPC dropped on a faulting instruction, applied otherwise
        step(1, 1, 0, EXC_RI, 0, 0, 1, 14, 32'h1234_5677, 32'h0000_3100);
        rd(14, 0);
        @(negedge clk); pin("drop_epc", dout, 32'h0000_3100);
        step(1, 1, 0, 0, 1, 0, 0, 13, 0, 32'h0000_4190);
        step(1, 1, 0, 0, 0, 0, 1, 14, 32'h1234_5677, 32'h0000_3200);
        rd(14, 0);
        @(negedge clk); pin("wr_epc", dout, 32'h1234_5674);

        // Reset asserted with an exception pending
        step(0, 1, 0, EXC_ADEL, 0, 0, 0, 14, 0, 32'h0000_3300);
        @(negedge clk); pin("rst_noredir", {31'b0, redirect}, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 12, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic er, w;
            c  = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(1, 4)] : 5'd0;
            a  = addrs[$urandom_range(0, 5)];
            er = ($urandom_range(0, 4) == 0);
            w  = !er && ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 c, er, 6'($urandom), w, a, $urandom, $urandom);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) pin("drain", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_redirect.md
Name: cp0_redirect

Overview:
- Coprocessor-0 block at the M stage that consumes the PC arriving from the EX/MEM pipeline register.
- Decides whether to take an interrupt or exception, or to execute eret.
- Records EPC, Cause and SR state.
- Drives the redirect (flush + new PC) back toward the F stage, in the opposite direction to the PC pipeline.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry PC.
- PRID_VAL, 32'h2019_0007, read-only PRId (reg 15) value.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- PC_M  in  32  PC of the instruction currently in M
- valid_M  in  1  M holds a real instruction (0 = bubble)
- BD_M  in  1  M instruction is in a branch delay slot
- ExcCode_M  in  5  synchronous exception code for M instr; 0 = none
- eret_M  in  1  M instruction is eret
- HWInt  in  6  external interrupt lines, level sensitive
- we  in  1  mtc0 write enable
- addr  in  5  CP0 register number for mfc0/mtc0
- din  in  32  mtc0 write data
- dout  out  32  mfc0 read data, combinational
- EPC_out  out  32  current EPC register
- redirect  out  1  flush F/D/E/M and load redirect_pc, combinational
- redirect_pc  out  32  target PC when redirect=1, else 0

Behaviour:
- Registers (read via dout; unimplemented addresses read 0):
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC (14): 32 bits, bits[1:0] forced 0.
  - PRId (15): PRID_VAL, not writable.
- Reset (reset=0, async): SR=0, Cause=0, EPC=0. Outputs: redirect=0, redirect_pc=0, EPC_out=0, dout=register value (0 except PRId).
- Combinational request terms:
  - int_req = valid_M & IE & !EXL & |(HWInt & IM)
  - exc_req = valid_M & !EXL & (ExcCode_M != 0)
  - take = int_req | exc_req
  - interrupt has priority over exception when both are pending.
- redirect = take | (eret_M & valid_M & !take).
- redirect_pc = HANDLER_PC if take; EPC if eret only; else 0.
- Same-cycle response: redirect asserts combinationally in the cycle of the request, zero latency. State updates at the next rising edge.
- On edge with take:
  - EXL<=1.
  - Cause.ExcCode <= int_req ? 0 : ExcCode_M.
  - Cause.BD <= BD_M.
  - EPC <= BD_M ? PC_M-4 : PC_M, then masked to word alignment.
- On edge with eret_M & valid_M & !take: EXL<=0. All other state unchanged.
- Cause.IP <= HWInt every edge, regardless of EXL/IE.
- mtc0:
  - Applied on the edge when we=1 and take=0; ignored when take=1 (faulting/interrupted instr must not commit).
  - addr 12 writes IM, EXL, IE only.
  - addr 14 writes EPC (bits[1:0] cleared).
  - Writes to 13 and 15 are ignored.
- No edge-triggered latching of HWInt: a deasserted line before sampling is simply lost.
- Bubbles (valid_M=0) never take interrupts, never commit eret, and never produce redirect. Interrupts are deferred until a valid instruction reaches M.
- Nested requests while EXL=1 are blocked. Only eret clears EXL.
- Reset asserted mid-request clears everything immediately. redirect drops combinationally because valid-derived terms use the reset SR.

Decomposition:
- Shared package/header holds:
  - CP0 register numbers (12, 13, 14, 15).
  - SR/Cause bit positions.
  - ExcCode values: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - HANDLER_PC default.
- No sub-module needed; single flat module with a small combinational request/priority section and one register always block.

Test Plan:
- Reset release, read addr 15 and 12 -> dout=32'h2019_0007, then 0. redirect=0, EPC_out=0.
- mtc0 SR=32'h0000_0401 (IM[10], IE); HWInt=6'b000001, PC_M=32'h0000_3010, valid_M=1 -> redirect=1, redirect_pc=32'h4180 same cycle. Next cycle: EPC=32'h3010, Cause.ExcCode=0, Cause.IP[10]=1, EXL=1.
- ExcCode_M=12 (Ov), BD_M=1, PC_M=32'h0000_3024, EXL=0 -> redirect_pc=32'h4180. EPC=32'h3020, Cause=32'h8000_0030.
- With EXL=1, EPC=32'h3020, eret_M=1 -> redirect_pc=32'h3020 same cycle. EXL=0 after edge.
- HWInt active with IE=1 but valid_M=0 for 3 cycles -> redirect stays 0. Taken on the first valid_M=1 cycle.
- we=1, addr=14, din=32'h1234_5677 coinciding with ExcCode_M=10 -> write dropped. EPC=PC_M, ExcCode=10. A separate write without an exception -> EPC=32'h1234_5674.
